// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared types for the systolic feed controller: one-hot state bit
// positions and the state enum built from them.
package feed_ctrl_pkg;

    localparam int IDLE_B = 0;
    localparam int RUN_B  = 1;
    localparam int DONE_B = 2;

    typedef enum logic [2:0] {
        IDLE = 3'(1 << IDLE_B),
        RUN  = 3'(1 << RUN_B),
        DONE = 3'(1 << DONE_B)
    } feed_ctrl_state_t;

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Lane-side bundle of the feed controller: FIFO consumer ports on one
// side, array west-edge feed on the other. The controller is the master.
interface systolic_feed_ctrl_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 16
);
    logic [LANES-1:0]       lane_empty;
    logic [LANES*WIDTH-1:0] lane_data;
    logic [LANES-1:0]       lane_r_en;
    logic [LANES*WIDTH-1:0] feed_data;
    logic [LANES-1:0]       feed_valid;

    modport master (
        input  lane_empty, lane_data,
        output lane_r_en, feed_data, feed_valid
    );

    modport slave (
        output lane_empty, lane_data,
        input  lane_r_en, feed_data, feed_valid
    );
endinterface

// File: rtl/feed_lane_window.sv
// Diagonal-skew window for one lane: active while LANE <= t < LANE + k_q.
// Compared in CNT_W+2 bits so LANE + k_q can never wrap.
module feed_lane_window #(
    parameter int LANE  = 0,
    parameter int CNT_W = 8
) (
    input  logic [CNT_W:0]   t,
    input  logic [CNT_W-1:0] k_q,
    output logic             active
);
    localparam logic [CNT_W+1:0] LO = (CNT_W+2)'(LANE);

    logic [CNT_W+1:0] t_ext;
    logic [CNT_W+1:0] hi;

    assign t_ext  = {1'b0, t};
    assign hi     = LO + {2'b00, k_q};
    assign active = (t_ext >= LO) && (t_ext < hi);
endmodule

// File: rtl/systolic_feed_ctrl.sv
// Systolic feed sequencer: drains k_len words per lane from show-ahead
// FIFOs in a diagonal wavefront, zero-padding idle lanes and stalling the
// whole front when any active lane is empty.
// Optional feature: define FEED_CTRL_ABORT_EN to add an 'abort' input.
module systolic_feed_ctrl
    import feed_ctrl_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
`ifdef FEED_CTRL_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic [CNT_W-1:0]     k_len,
    systolic_feed_ctrl_if.master bus,
    output logic                 busy,
    output logic                 done
);

    feed_ctrl_state_t       state_q, state_d;
    logic [CNT_W-1:0]       k_q, k_d;
    logic [CNT_W:0]         t_q, t_d;
    logic [LANES*WIDTH-1:0] feed_data_q, feed_data_d;
    logic [LANES-1:0]       feed_valid_q, feed_valid_d;

    logic [LANES-1:0] active;
    logic [LANES-1:0] r_en;
    logic             stall;
    logic             abort_w;
    logic [CNT_W:0]   last_t;

`ifdef FEED_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_win
        feed_lane_window #(
            .LANE  (g),
            .CNT_W (CNT_W)
        ) u_win (
            .t      (t_q),
            .k_q    (k_q),
            .active (active[g])
        );
    end

    assign last_t = (CNT_W+1)'(k_q) + (CNT_W+1)'(LANES - 2);
    assign stall  = |(active & bus.lane_empty);
    assign r_en   = (state_q[RUN_B] && !stall && !abort_w) ? active : '0;

    // Next-state, beat counter and feed register computation.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        k_d          = k_q;
        t_d          = t_q;
        feed_valid_d = r_en;
        feed_data_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            feed_data_d[i*WIDTH +: WIDTH] = r_en[i] ? bus.lane_data[i*WIDTH +: WIDTH] : '0;
        end
        case (state_q)
            IDLE: begin
                if (start && !abort_w) begin
                    k_d     = k_len;
                    t_d     = '0;
                    state_d = (k_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_w) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    t_d = t_q + 1'b1;
                    if (t_q == last_t) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All controller state, reset asynchronously to an idle, silent front.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            state_q      <= IDLE;
            k_q          <= '0;
            t_q          <= '0;
            feed_data_q  <= '0;
            feed_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            t_q          <= t_d;
            feed_data_q  <= feed_data_d;
            feed_valid_q <= feed_valid_d;
        end
    end

    assign bus.lane_r_en  = r_en;
    assign bus.feed_data  = feed_data_q;
    assign bus.feed_valid = feed_valid_q;
    assign busy           = !state_q[IDLE_B];
    assign done           = state_q[DONE_B] && !abort_w;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl (LANES=4, WIDTH=16): skew, stall,
// zero length, start-while-busy, async reset and (optionally) abort.
module tb_systolic_feed_ctrl;

    localparam int LANES = 4;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [CNT_W-1:0] k_len;
    logic             busy;
    logic             done;
`ifdef FEED_CTRL_ABORT_EN
    logic             abort;
`endif

    systolic_feed_ctrl_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

    systolic_feed_ctrl #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rstn  (rstn),
`ifdef FEED_CTRL_ABORT_EN
        .abort (abort),
`endif
        .start (start),
        .k_len (k_len),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: pop_cnt advances on each DUT pop; the
    // initial block refills by moving base/limit past it.
    int unsigned pop_cnt [LANES];
    int unsigned base    [LANES];
    int unsigned limit   [LANES];
    logic [LANES-1:0] force_empty;
    int done_cnt = 0;

    function automatic logic [WIDTH-1:0] word(input int i, input int j);
        return WIDTH'(32'hA000 + i * 256 + j);
    endfunction

    initial begin
        for (int i = 0; i < LANES; i++) begin
            pop_cnt[i] = 0;
            base[i]    = 0;
            limit[i]   = 0;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            bus.lane_empty[i] = force_empty[i] || (pop_cnt[i] >= limit[i]);
            bus.lane_data[i*WIDTH +: WIDTH] = word(i, int'(pop_cnt[i] - base[i]));
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (bus.lane_r_en[i]) pop_cnt[i] <= pop_cnt[i] + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    // Scoreboard for the registered feed outputs.
    logic [LANES-1:0]       exp_valid = '0;
    logic [LANES*WIDTH-1:0] exp_data  = '0;
    int                     exp_pops [LANES];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: check pops and registered feed, advance the scoreboard.
    task automatic step(input string tag, input logic [LANES-1:0] ren);
        #1;
        check({tag, " r_en"},  64'(bus.lane_r_en), 64'(ren));
        check({tag, " valid"}, 64'(bus.feed_valid), 64'(exp_valid));
        check({tag, " data"},  64'(bus.feed_data), 64'(exp_data));
        check({tag, " pop_empty"}, 64'(bus.lane_r_en & bus.lane_empty), 64'(0));
        exp_valid = ren;
        exp_data  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (ren[i]) begin
                exp_data[i*WIDTH +: WIDTH] = word(i, exp_pops[i]);
                exp_pops[i]++;
            end
        end
        tick();
    endtask

    task automatic start_tile(input int k, input int n);
        for (int i = 0; i < LANES; i++) begin
            base[i]     = pop_cnt[i];
            limit[i]    = pop_cnt[i] + n;
            exp_pops[i] = 0;
        end
        k_len = CNT_W'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [3:0] seq_k3 [6] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
    logic [3:0] seq_k5 [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hE, 4'hC, 4'h8};
    int done_before;

    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        k_len       = '0;
        force_empty = '0;
`ifdef FEED_CTRL_ABORT_EN
        abort       = 1'b0;
`endif
        repeat (2) tick();
        check("rst busy",  64'(busy), 64'(0));
        check("rst done",  64'(done), 64'(0));
        check("rst r_en",  64'(bus.lane_r_en), 64'(0));
        check("rst valid", 64'(bus.feed_valid), 64'(0));
        check("rst data",  64'(bus.feed_data), 64'(0));
        rstn = 1'b1;
        tick();

        // 1: basic skew, k=3
        start_tile(3, 3);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("t1 busy c%0d", c), 64'(busy), 64'(1));
            step($sformatf("t1 c%0d", c), seq_k3[c]);
        end
        check("t1 done",      64'(done), 64'(1));
        check("t1 done busy", 64'(busy), 64'(1));
        step("t1 dn", 4'h0);
        check("t1 idle done", 64'(done), 64'(0));
        check("t1 idle busy", 64'(busy), 64'(0));
        step("t1 idle", 4'h0);

        // 2: lane 2 empty for two cycles when t=2 is first reached
        start_tile(3, 3);
        step("t2 c0", 4'h1);
        step("t2 c1", 4'h3);
        force_empty[2] = 1'b1;
        check("t2 t hold a", 64'(dut.t_q), 64'(2));
        step("t2 c2", 4'h0);
        check("t2 t hold b", 64'(dut.t_q), 64'(2));
        step("t2 c3", 4'h0);
        force_empty[2] = 1'b0;
        step("t2 c4", 4'h7);
        step("t2 c5", 4'hE);
        step("t2 c6", 4'hC);
        check("t2 busy last", 64'(busy), 64'(1));
        step("t2 c7", 4'h8);
        check("t2 done", 64'(done), 64'(1));
        step("t2 dn", 4'h0);
        check("t2 idle", 64'(busy), 64'(0));

        // 3: zero length
        start_tile(0, 0);
        check("t3 done", 64'(done), 64'(1));
        check("t3 busy", 64'(busy), 64'(1));
        step("t3 dn", 4'h0);
        check("t3 idle done", 64'(done), 64'(0));
        step("t3 idle", 4'h0);

        // 4: start while busy is ignored
        done_before = done_cnt;
        start_tile(5, 5);
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                start = 1'b1;
                k_len = 8'd1;
            end
            step($sformatf("t4 c%0d", c), seq_k5[c]);
            start = 1'b0;
        end
        check("t4 done", 64'(done), 64'(1));
        step("t4 dn", 4'h0);
        step("t4 idle", 4'h0);
        check("t4 one done", 64'(done_cnt - done_before), 64'(1));
        for (int i = 0; i < LANES; i++)
            check($sformatf("t4 pops l%0d", i), 64'(pop_cnt[i] - base[i]), 64'(5));

        // 5: async reset mid-RUN at t=3
        done_before = done_cnt;
        start_tile(3, 3);
        step("t5 c0", 4'h1);
        step("t5 c1", 4'h3);
        step("t5 c2", 4'h7);
        #2;
        rstn = 1'b0;
        #1;
        check("t5 rst r_en",  64'(bus.lane_r_en), 64'(0));
        check("t5 rst valid", 64'(bus.feed_valid), 64'(0));
        check("t5 rst data",  64'(bus.feed_data), 64'(0));
        check("t5 rst busy",  64'(busy), 64'(0));
        check("t5 rst done",  64'(done), 64'(0));
        tick();
        rstn      = 1'b1;
        exp_valid = '0;
        exp_data  = '0;
        tick();
        check("t5 no done", 64'(done_cnt - done_before), 64'(0));
        start_tile(3, 3);
        for (int c = 0; c < 6; c++)
            step($sformatf("t5r c%0d", c), seq_k3[c]);
        check("t5r done", 64'(done), 64'(1));
        step("t5r dn", 4'h0);

`ifdef FEED_CTRL_ABORT_EN
        // 6: abort at t=1
        done_before = done_cnt;
        start_tile(3, 3);
        step("t6 c0", 4'h1);
        abort = 1'b1;
        step("t6 ab", 4'h0);
        abort = 1'b0;
        check("t6 busy",  64'(busy), 64'(0));
        check("t6 done",  64'(done), 64'(0));
        check("t6 valid", 64'(bus.feed_valid), 64'(0));
        tick();
        check("t6 no done", 64'(done_cnt - done_before), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
